// File: rtl/circuit1_bist_ctrl_if.sv
// Bus between a BIST host/CUT harness and circuit1_bist_ctrl.
// The slave side is the controller; the master side is the host plus the CUT response.
interface circuit1_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic       cut_z;
    logic       cut_x1;
    logic       cut_x2;
    logic       cut_x3;
    logic       cut_cd_n;
    logic       cut_sd_n;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;

    modport slave (
        input  start, abort, cut_z,
        output cut_x1, cut_x2, cut_x3, cut_cd_n, cut_sd_n,
        output busy, done, pass, signature
    );

    modport master (
        output start, abort, cut_z,
        input  cut_x1, cut_x2, cut_x3, cut_cd_n, cut_sd_n,
        input  busy, done, pass, signature
    );
endinterface

// File: rtl/circuit1_bist_ctrl.sv
// BIST controller for circuit1: clears the CUT flop, walks PAT_CNT patterns,
// compacts the 1-cycle-late response into an 8-bit MISR and compares it to GOLDEN.
module circuit1_bist_ctrl #(
    parameter int unsigned PAT_CNT = 8,
    parameter logic [7:0]  GOLDEN  = 8'h00
) (
    input  logic                  CP,
    input  logic                  CD,
    circuit1_bist_ctrl_if.slave   bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_APPLY   = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [3:0] LAST_CNT = 4'(PAT_CNT - 1);

    logic [2:0] state;
    logic       init_ph;   // 0: clear pulse to the CUT flop, 1: release
    logic [3:0] cnt;
    logic [7:0] sig;
    logic       pass_q;
    logic       busy;

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic z);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, z};
    endfunction

    assign busy = (state == S_INIT) || (state == S_APPLY) ||
                  (state == S_FLUSH) || (state == S_COMPARE);

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples pre-edge values; the reset is synchronous and checked first.
    always_ff @(posedge CP) begin
        if (CD) begin
            state   <= S_IDLE;
            init_ph <= 1'b0;
            cnt     <= 4'd0;
            sig     <= 8'h00;
            pass_q  <= 1'b0;
        end else if (busy && bus.abort) begin
            state   <= S_IDLE;
            init_ph <= 1'b0;
            cnt     <= 4'd0;
            sig     <= 8'h00;
            pass_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state   <= S_INIT;
                        init_ph <= 1'b0;
                        cnt     <= 4'd0;
                        sig     <= 8'h00;
                        pass_q  <= 1'b0;
                    end
                end
                S_INIT: begin
                    if (init_ph) begin
                        init_ph <= 1'b0;
                        state   <= S_APPLY;
                    end else begin
                        init_ph <= 1'b1;
                    end
                end
                S_APPLY: begin
                    cnt <= cnt + 4'd1;
                    // Response to pattern cnt-1 arrives while pattern cnt is applied.
                    if (cnt != 4'd0)
                        sig <= misr_step(sig, bus.cut_z);
                    if (cnt == LAST_CNT)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    sig   <= misr_step(sig, bus.cut_z);
                    state <= S_COMPARE;
                end
                S_COMPARE: begin
                    pass_q <= (sig == GOLDEN);
                    state  <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign {bus.cut_x1, bus.cut_x2, bus.cut_x3} = (state == S_APPLY) ? cnt[2:0] : 3'b000;
    assign bus.cut_cd_n  = !((state == S_INIT) && !init_ph);
    assign bus.cut_sd_n  = 1'b1;
    assign bus.busy      = busy;
    assign bus.done      = (state == S_DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig;

endmodule

// File: tb/tb_circuit1_bist_ctrl.sv
// Self-checking bench: three controller instances (8 patterns / golden 00, 8 / FF, 1 / 00)
// run in lockstep against a schedule and MISR reference model.
module tb_circuit1_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       z_mode;   // 0: constant response, 1: truth-table CUT
    logic       z_const;
    logic [7:0] truth;
    int         n_checks = 0;
    int         n_fails  = 0;

    always #5 clk = ~clk;

    circuit1_bist_ctrl_if ia ();
    circuit1_bist_ctrl_if ib ();
    circuit1_bist_ctrl_if ic ();

    circuit1_bist_ctrl #(.PAT_CNT(8), .GOLDEN(8'h00)) u_a (.CP(clk), .CD(rst), .bus(ia));
    circuit1_bist_ctrl #(.PAT_CNT(8), .GOLDEN(8'hFF)) u_b (.CP(clk), .CD(rst), .bus(ib));
    circuit1_bist_ctrl #(.PAT_CNT(1), .GOLDEN(8'h00)) u_c (.CP(clk), .CD(rst), .bus(ic));

    // Behavioural CUT: registered truth-table lookup of the applied pattern.
    logic za_q, zb_q, zc_q;
    always @(posedge clk) begin
        za_q <= truth[{ia.cut_x1, ia.cut_x2, ia.cut_x3}];
        zb_q <= truth[{ib.cut_x1, ib.cut_x2, ib.cut_x3}];
        zc_q <= truth[{ic.cut_x1, ic.cut_x2, ic.cut_x3}];
    end

    assign ia.start = start;
    assign ib.start = start;
    assign ic.start = start;
    assign ia.abort = abort;
    assign ib.abort = abort;
    assign ic.abort = abort;
    assign ia.cut_z = z_mode ? za_q : z_const;
    assign ib.cut_z = z_mode ? zb_q : z_const;
    assign ic.cut_z = z_mode ? zc_q : z_const;

    // Expected signature: fold the responses to patterns 0..n-1 through the MISR polynomial.
    function automatic logic [7:0] model_sig(input int n);
        logic [7:0] s;
        logic       z;
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            z = z_mode ? truth[i] : z_const;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, z};
        end
        return s;
    endfunction

    // Expected {cd_n, sd_n, x1, x2, x3, busy, done} k cycles after start was sampled.
    function automatic logic [6:0] model_ctrl(input int n, input int k);
        logic [2:0] pat;
        pat = 3'(k - 2);
        if (k == 0) return 7'b0_1_000_1_0;
        if (k == 1 || k == n + 2 || k == n + 3) return 7'b1_1_000_1_0;
        if (k <= n + 1) return {2'b11, pat, 2'b10};
        return 7'b1_1_000_0_1;
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ia.cut_cd_n, ia.cut_sd_n, ia.cut_x1, ia.cut_x2, ia.cut_x3, ia.busy, ia.done, ia.pass, ia.signature} !== 16'b11_000_000_0000_0000) begin
            n_fails++;
            $display("FAIL reset_a: got cd_n=%b sd_n=%b x=%b%b%b busy=%b done=%b pass=%b sig=%h, expected 1 1 000 0 0 0 00",
                     ia.cut_cd_n, ia.cut_sd_n, ia.cut_x1, ia.cut_x2, ia.cut_x3, ia.busy, ia.done, ia.pass, ia.signature);
        end
        n_checks++;
        if ({ic.busy, ic.done, ic.pass, ic.signature, ib.busy, ib.done, ib.signature} !== 21'h0) begin
            n_fails++;
            $display("FAIL reset_bc: got c busy=%b done=%b pass=%b sig=%h b busy=%b done=%b sig=%h, expected all 0",
                     ic.busy, ic.done, ic.pass, ic.signature, ib.busy, ib.done, ib.signature);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ia.busy, ia.done} !== 2'b00) begin
            n_fails++;
            $display("FAIL idle_hold: got busy=%b done=%b, expected 0 0", ia.busy, ia.done);
        end
    endtask

    // Starts a run from IDLE/DONE and checks the whole schedule and results; an optional
    // start pulse at cycle pulse_k (while busy) must change nothing.
    task automatic run_and_check(input string name, input int pulse_k);
        logic [7:0] ea, ec;
        logic       pa, pb, pc;
        ea = model_sig(8);
        ec = model_sig(1);
        pa = (ea == 8'h00);
        pb = (ea == 8'hFF);
        pc = (ec == 8'h00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({ia.signature, ia.pass, ib.signature, ib.pass, ic.signature, ic.pass} !== 27'h0) begin
            n_fails++;
            $display("FAIL %s entry_clear: got a=%h/%b b=%h/%b c=%h/%b, expected 00/0 for all",
                     name, ia.signature, ia.pass, ib.signature, ib.pass, ic.signature, ic.pass);
        end
        for (int k = 0; k <= 12; k++) begin
            n_checks++;
            if ({ia.cut_cd_n, ia.cut_sd_n, ia.cut_x1, ia.cut_x2, ia.cut_x3, ia.busy, ia.done} !== model_ctrl(8, k)) begin
                n_fails++;
                $display("FAIL %s ctrl_a k=%0d: got %b, expected %b", name, k,
                         {ia.cut_cd_n, ia.cut_sd_n, ia.cut_x1, ia.cut_x2, ia.cut_x3, ia.busy, ia.done}, model_ctrl(8, k));
            end
            n_checks++;
            if ({ic.cut_cd_n, ic.cut_sd_n, ic.cut_x1, ic.cut_x2, ic.cut_x3, ic.busy, ic.done} !== model_ctrl(1, k)) begin
                n_fails++;
                $display("FAIL %s ctrl_c k=%0d: got %b, expected %b", name, k,
                         {ic.cut_cd_n, ic.cut_sd_n, ic.cut_x1, ic.cut_x2, ic.cut_x3, ic.busy, ic.done}, model_ctrl(1, k));
            end
            if (k == 5 || k == 12) begin
                n_checks++;
                if ({ic.signature, ic.pass} !== {ec, pc}) begin
                    n_fails++;
                    $display("FAIL %s result_c k=%0d: got sig=%h pass=%b, expected sig=%h pass=%b",
                             name, k, ic.signature, ic.pass, ec, pc);
                end
            end
            if (k == 12) begin
                n_checks++;
                if ({ia.signature, ia.pass, ib.signature, ib.pass} !== {ea, pa, ea, pb}) begin
                    n_fails++;
                    $display("FAIL %s result_ab: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b",
                             name, ia.signature, ia.pass, ib.signature, ib.pass, ea, pa, ea, pb);
                end
            end
            if (k < 12) begin
                start = (k == pulse_k);
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic test_zero_response();
        z_mode  = 1'b0;
        z_const = 1'b0;
        run_and_check("zero", -1);
    endtask

    task automatic test_stuck_one();
        z_mode  = 1'b0;
        z_const = 1'b1;
        run_and_check("stuck1", -1);
    endtask

    task automatic test_ignored_start();
        z_mode = 1'b1;
        truth  = 8'($urandom);
        run_and_check("ignored_start", 3);
    endtask

    task automatic test_abort();
        z_mode  = 1'b0;
        z_const = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({ia.busy, ia.cut_x1, ia.cut_x2, ia.cut_x3} !== 4'b1_011) begin
            n_fails++;
            $display("FAIL abort_pre: got busy=%b x=%b%b%b, expected busy=1 x=011",
                     ia.busy, ia.cut_x1, ia.cut_x2, ia.cut_x3);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({ia.busy, ia.done, ia.pass, ia.signature, ia.cut_x1, ia.cut_x2, ia.cut_x3, ia.cut_cd_n} !== 15'b000_0000_0000_0001) begin
            n_fails++;
            $display("FAIL abort_a: got busy=%b done=%b pass=%b sig=%h x=%b%b%b cd_n=%b, expected 0 0 0 00 000 1",
                     ia.busy, ia.done, ia.pass, ia.signature, ia.cut_x1, ia.cut_x2, ia.cut_x3, ia.cut_cd_n);
        end
        n_checks++;
        if ({ib.busy, ib.signature} !== 9'h0) begin
            n_fails++;
            $display("FAIL abort_b: got busy=%b sig=%h, expected 0 00", ib.busy, ib.signature);
        end
        n_checks++;
        if ({ic.done, ic.signature} !== {1'b1, model_sig(1)}) begin
            n_fails++;
            $display("FAIL abort_ignored_in_done: got done=%b sig=%h, expected 1 %h", ic.done, ic.signature, model_sig(1));
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ia.busy, ia.done} !== 2'b00) begin
            n_fails++;
            $display("FAIL abort_stays_idle: got busy=%b done=%b, expected 0 0", ia.busy, ia.done);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            z_mode = 1'b1;
            truth  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_and_check("random", -1);
        end
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        z_mode = 1'b1;
        truth  = 8'($urandom) | 8'h01;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({ia.busy, ia.done, ia.pass, ia.signature, ic.done, ic.signature} !== 20'h0) begin
            n_fails++;
            $display("FAIL reset_mid_run: got a busy=%b done=%b pass=%b sig=%h c done=%b sig=%h, expected all 0",
                     ia.busy, ia.done, ia.pass, ia.signature, ic.done, ic.signature);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            saw_done = saw_done | ia.done;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_no_result: got done asserted after mid-run reset, expected none");
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        z_mode  = 1'b0;
        z_const = 1'b0;
        truth   = 8'h00;
        test_reset();
        test_zero_response();
        test_stuck_one();
        test_ignored_start();
        test_abort();
        test_random();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
